// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between the core (m0) and the
// UART loader / debug DMA (m1). It makes at most one access per cycle and keeps at
// most one read outstanding. Round-robin arbitration; the grant is zero-latency.
// Optional feature macro: MEM_PORT_ARBITER_LOCK_EN. It adds the m1_lock input, which
// lets the loader keep the port for uninterrupted bursts.
module mem_port_arbiter #(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_wdata,
`ifdef MEM_PORT_ARBITER_LOCK_EN
    input  logic          m1_lock,
`endif
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // RD_LAT is limited to 1..4, so the countdown never exceeds 3.
    localparam int unsigned CW = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t        r_state;
    logic          r_last;
    logic [CW-1:0] r_lat_cnt;
    logic          r_owner;

    logic          w_ret;
    logic          w_issue_ok;
    logic          w_req0;
    logic          w_win;
    logic          w_issue;
    logic          w_we_sel;

    // The return cycle of the outstanding read; it is also an issue slot.
    assign w_ret      = !rst && (r_state == RD_WAIT) && (r_lat_cnt == CW'(0));
    assign w_issue_ok = !rst && ((r_state == IDLE) || (r_lat_cnt == CW'(0)));

    // The loader lock hides the core's request only while the loader holds `last`.
`ifdef MEM_PORT_ARBITER_LOCK_EN
    assign w_req0 = m0_req && !(m1_lock && r_last);
`else
    assign w_req0 = m0_req;
`endif

    // Round-robin: a lone requester wins; on a tie the one that did not go last wins.
    assign w_win    = (w_req0 && m1_req) ? ~r_last : m1_req;
    assign w_issue  = w_issue_ok && (w_req0 || m1_req);
    assign w_we_sel = w_win ? m1_we : m0_we;

    // Zero-latency grant and memory-side mux; the bus is driven to 0 when idle.
    assign m0_gnt    = w_issue && !w_win;
    assign m1_gnt    = w_issue && w_win;
    assign mem_en    = w_issue;
    assign mem_we    = w_issue && w_we_sel;
    assign mem_adr   = w_issue ? (w_win ? m1_adr : m0_adr) : '0;
    assign mem_wdata = w_issue ? (w_win ? m1_wdata : m0_wdata) : '0;

    // Read data is returned only to the owner, and only in the return cycle.
    assign m0_rvalid = w_ret && !r_owner;
    assign m1_rvalid = w_ret && r_owner;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

    // Arbitration history and read-tracking state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_lat_cnt <= '0;
            r_owner   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_last <= w_win;
            end
            if (w_issue && !w_we_sel) begin
                r_owner   <= w_win;
                r_state   <= RD_WAIT;
                r_lat_cnt <= CW'(RD_LAT - 1);
            end else if (r_state == RD_WAIT) begin
                if (r_lat_cnt == CW'(0)) begin
                    r_state <= IDLE;
                end else begin
                    r_lat_cnt <= r_lat_cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (RD_LAT 1, 3 and 4), each with its own
// requesters, memory and scoreboard model, plus directed literal checks.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int NI = 3;
    localparam int RANDOM_CYCLES = 1500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Memory contents as a pure function of the address; 0x40 holds 0x12345678.
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 32'h40) return 32'h1234_5678;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d cyc%0d: got %h expected %h", name, inst, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

        logic          rst;
        logic          m0_req, m0_we, m0_gnt, m0_rvalid;
        logic [AW-1:0] m0_adr;
        logic [DW-1:0] m0_wdata, m0_rdata;
        logic          m1_req, m1_we, m1_gnt, m1_rvalid;
        logic [AW-1:0] m1_adr;
        logic [DW-1:0] m1_wdata, m1_rdata;
`ifdef MEM_PORT_ARBITER_LOCK_EN
        logic          m1_lock;
`endif
        logic          mem_en, mem_we;
        logic [AW-1:0] mem_adr;
        logic [DW-1:0] mem_wdata, mem_rdata;

        bit            fin = 1'b0;
        bit [1:0]      got_gnt = 2'b00;
        bit            hv [8];
        logic [AW-1:0] ha [8];

        // Scoreboard model: last winner plus the single pending read and its due cycle.
        int            md_last = 1;
        bit            pv = 1'b0;
        int            pown = 0;
        logic [AW-1:0] padr = '0;
        int            pdue = 0;

        mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
            .clk       (clk),
            .rst       (rst),
            .m0_req    (m0_req),
            .m0_we     (m0_we),
            .m0_adr    (m0_adr),
            .m0_wdata  (m0_wdata),
            .m0_gnt    (m0_gnt),
            .m0_rvalid (m0_rvalid),
            .m0_rdata  (m0_rdata),
            .m1_req    (m1_req),
            .m1_we     (m1_we),
            .m1_adr    (m1_adr),
            .m1_wdata  (m1_wdata),
`ifdef MEM_PORT_ARBITER_LOCK_EN
            .m1_lock   (m1_lock),
`endif
            .m1_gnt    (m1_gnt),
            .m1_rvalid (m1_rvalid),
            .m1_rdata  (m1_rdata),
            .mem_en    (mem_en),
            .mem_we    (mem_we),
            .mem_adr   (mem_adr),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata)
        );

        // Advance one cycle; the memory returns data for the read issued LAT cycles earlier.
        task automatic step();
            int k;
            @(posedge clk);
            #1;
            k = cyc - int'(LAT);
            if (k >= 0 && hv[k % 8]) mem_rdata = mem_fn(ha[k % 8]);
            else                     mem_rdata = $urandom;
        endtask

        task automatic new_req(input int j);
            logic          rq;
            logic          we;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            rq = ($urandom_range(0, 3) != 0);
            we = $urandom_range(0, 1) == 1;
            a  = AW'($urandom_range(0, 255)) << 2;
            d  = $urandom;
            if (j == 0) begin m0_req = rq; m0_we = we; m0_adr = a; m0_wdata = d; end
            else        begin m1_req = rq; m1_we = we; m1_adr = a; m1_wdata = d; end
        endtask

        // Every cycle: check all outputs against the model, then advance the model.
        always @(negedge clk) begin : cmp
            bit c0, c1, ok, ret, win, wr, issue;
            logic [5:0]  e_ctl;
            logic [63:0] e_bus, e_rd;
            c0 = m0_req;
            c1 = m1_req;
`ifdef MEM_PORT_ARBITER_LOCK_EN
            if (m1_lock && md_last == 1) c0 = 1'b0;
`endif
            ret   = !rst && pv && (cyc == pdue);
            ok    = !rst && (!pv || cyc == pdue);
            win   = (c0 && c1) ? (md_last == 0) : c1;
            issue = ok && (c0 || c1);
            wr    = win ? m1_we : m0_we;
            e_ctl = {issue && !win, issue && win, ret && pown == 0, ret && pown == 1, issue, issue && wr};
            e_bus = issue ? {(win ? m1_adr : m0_adr), (win ? m1_wdata : m0_wdata)} : 64'd0;
            e_rd  = {((ret && pown == 0) ? mem_fn(padr) : 32'd0), ((ret && pown == 1) ? mem_fn(padr) : 32'd0)};
            chk("ctl", g, 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we}), 64'(e_ctl));
            chk("bus", g, {mem_adr, mem_wdata}, e_bus);
            chk("rdata", g, {m0_rdata, m1_rdata}, e_rd);
            got_gnt = {m1_gnt, m0_gnt};
            hv[cyc % 8] = mem_en && !mem_we;
            ha[cyc % 8] = mem_adr;
            if (rst) begin
                md_last = 1;
                pv      = 1'b0;
            end else begin
                if (ret) pv = 1'b0;
                if (issue) begin
                    md_last = win ? 1 : 0;
                    if (!wr) begin
                        pv   = 1'b1;
                        pown = win ? 1 : 0;
                        padr = win ? m1_adr : m0_adr;
                        pdue = cyc + int'(LAT);
                    end
                end
            end
        end

        initial begin : drv
            rst = 1'b1;
            m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h10; m0_wdata = '0;
            m1_req = 1'b1; m1_we = 1'b0; m1_adr = 32'h20; m1_wdata = '0;
            mem_rdata = '0;
`ifdef MEM_PORT_ARBITER_LOCK_EN
            m1_lock = 1'b0;
`endif
            // Two reset cycles with both requesting: everything stays quiet.
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                chk("rst_quiet", g, 64'({m0_gnt, m1_gnt, mem_en, m0_rvalid, m1_rvalid}), 64'd0);
                step();
            end
            rst = 1'b0;
            @(negedge clk);
            chk("first_gnt", g, 64'({m0_gnt, m1_gnt, mem_en}), 64'(3'b101));
            step();
            m0_req = 1'b0; m1_req = 1'b0;
            repeat (LAT + 1) step();

            // Single write from the loader.
            m1_req = 1'b1; m1_we = 1'b1; m1_adr = 32'h100; m1_wdata = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("wr_ctl", g, 64'({m1_gnt, mem_en, mem_we}), 64'(3'b111));
            chk("wr_bus", g, {mem_adr, mem_wdata}, {32'h100, 32'hDEAD_BEEF});
            step();
            m1_req = 1'b0;
            for (int i = 0; i < int'(LAT) + 1; i++) begin
                @(negedge clk);
                chk("wr_no_rv", g, 64'({m0_rvalid, m1_rvalid}), 64'd0);
                step();
            end

            if (LAT == 3) begin
                // Read latency: the port is blocked until the return cycle.
                m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h40;
                @(negedge clk);
                chk("rd_gnt", g, 64'(m0_gnt), 64'd1);
                step();
                m0_req = 1'b0;
                m1_req = 1'b1; m1_we = 1'b1; m1_adr = 32'h200; m1_wdata = 32'h5555_AAAA;
                for (int i = 0; i < 2; i++) begin
                    @(negedge clk);
                    chk("rd_blocked", g, 64'({m0_gnt, m1_gnt, mem_en, m0_rvalid}), 64'd0);
                    step();
                end
                @(negedge clk);
                chk("rd_return", g, 64'({m0_rvalid, m0_rdata}), 64'({1'b1, 32'h1234_5678}));
                chk("rd_b2b_gnt", g, 64'(m1_gnt), 64'd1);
                step();
                m1_req = 1'b0;
                step();
            end

            if (LAT == 1) begin
                // Contention: grants alternate, each rvalid one cycle after its grant.
                m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h300;
                m1_req = 1'b1; m1_we = 1'b0; m1_adr = 32'h304;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("cont_gnt", g, 64'({m0_gnt, m1_gnt}), (i % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
                    if (i > 0) chk("cont_rv", g, 64'({m0_rvalid, m1_rvalid}), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
                    step();
                end
                m0_req = 1'b0; m1_req = 1'b0;
                step();
`ifdef MEM_PORT_ARBITER_LOCK_EN
                // Loader lock: m1 keeps the port while locked, m0 gets it once released.
                m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h308;
                m1_req = 1'b1; m1_we = 1'b0; m1_adr = 32'h30C; m1_lock = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("lock_gnt", g, 64'({m0_gnt, m1_gnt}), 64'(2'b01));
                    step();
                end
                m1_lock = 1'b0;
                @(negedge clk);
                chk("lock_release", g, 64'({m0_gnt, m1_gnt}), 64'(2'b10));
                step();
                m0_req = 1'b0; m1_req = 1'b0;
                step();
`endif
            end

            if (LAT == 4) begin
                // Reset in the middle of a read discards it.
                m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h80;
                @(negedge clk);
                chk("mid_gnt", g, 64'(m0_gnt), 64'd1);
                step();
                m0_req = 1'b0;
                step();
                rst = 1'b1;
                @(negedge clk);
                chk("mid_rst_rv", g, 64'(m0_rvalid), 64'd0);
                step();
                rst = 1'b0;
                m0_req = 1'b1; m0_adr = 32'h84;
                @(negedge clk);
                chk("post_rst_gnt", g, 64'(m0_gnt), 64'd1);
                step();
                m0_req = 1'b0;
                @(negedge clk);
                chk("no_stale_rv", g, 64'(m0_rvalid), 64'd0);
                repeat (LAT + 1) step();
            end

            // Randomized traffic with occasional resets; the model checks every cycle.
            for (int n = 0; n < RANDOM_CYCLES; n++) begin
                step();
                if (rst) rst = 1'b0;
                else if ($urandom_range(0, 99) == 0) rst = 1'b1;
                if (got_gnt[0] || !m0_req) new_req(0);
                if (got_gnt[1] || !m1_req) new_req(1);
`ifdef MEM_PORT_ARBITER_LOCK_EN
                if ($urandom_range(0, 7) == 0) m1_lock = ~m1_lock;
`endif
            end
            step();
            rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
            repeat (8) step();
            fin = 1'b1;
        end
    end

    initial begin : top
        int waited;
        waited = 0;
        while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) && waited < 20000) begin
            @(posedge clk);
            waited++;
        end
        if (waited >= 20000) begin
            miscompares++;
            $display("FAIL timeout: got %0d cycles without completion, required under 20000", waited);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port (address, write data, write enable, read data) between two requesters.
- Requester 0 is the multi-cycle core. Requester 1 is the UART program loader / debug DMA.
- Issues at most one access per cycle, holds at most one read in flight, and returns read data to the owner after a fixed memory latency.
- Sits between the core top level and the memory block.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- RD_LAT, 1, memory read latency in cycles from issue to valid mem_rdata; legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_req  in  1  core access request; held until m0_gnt
- m0_we  in  1  core write enable, qualified by m0_req
- m0_adr  in  AW  core address
- m0_wdata  in  DW  core write data
- m0_gnt  out  1  access issued to memory this cycle
- m0_rvalid  out  1  core read data valid, one-cycle pulse
- m0_rdata  out  DW  core read data
- m1_req, m1_we, m1_adr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0_*, for the loader
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_adr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after a read issue

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, last=1 (so m0 wins the first tie), lat_cnt=0, owner=0. All outputs 0.
- States:
  - IDLE: no read outstanding.
  - RD_WAIT: read outstanding; lat_cnt counts down from RD_LAT-1.
- Issue rule: an issue is allowed when state==IDLE, or when state==RD_WAIT and lat_cnt==0 (the return cycle).
- Arbitration (round-robin, combinational):
  - Candidates are the requesters with req=1.
  - One candidate: it wins.
  - Both: the requester not equal to `last` wins.
- On issue:
  - Winner's gnt=1 for that cycle only.
  - mem_en=1; mem_we/mem_adr/mem_wdata are muxed from the winner in the same cycle (zero-latency grant).
  - `last` <= winner.
- Write:
  - Completes at gnt.
  - No rvalid.
  - State returns to (or stays) IDLE unless a read is issued in the same cycle.
- Read:
  - owner <= winner. State -> RD_WAIT, lat_cnt <= RD_LAT-1.
  - Decrement lat_cnt each cycle.
  - When lat_cnt==0: m{owner}_rvalid=1 and m{owner}_rdata=mem_rdata. If no new read issues that cycle, state -> IDLE.
- Back-to-back reads: when a new issue coincides with the return cycle, the rvalid for the previous read and the gnt for the next access assert in the same cycle, giving full throughput at RD_LAT=1.
- No issue cycle: mem_en=0, mem_we=0. mem_adr and mem_wdata are don't-care but driven 0.
- Non-owner rdata is 0; the rdata of a requester with rvalid=0 is also 0.
- Requester contract:
  - req must stay high and adr/we/wdata stable until gnt.
  - Deasserting req before gnt is a protocol violation; the arbiter may still issue in that cycle.
- Reset mid-read: the outstanding read is discarded, no rvalid is produced, and all state returns to reset values on the next edge.
- mem_we is never asserted without mem_en.

Optional Feature:
- Macro: MEM_PORT_ARBITER_LOCK_EN.
- When defined:
  - Adds input port m1_lock (1 bit).
  - While m1_lock=1 and `last`==1, m0 is never granted; m1 wins even when m0 is requesting.
  - The lock releases on the first cycle m1_lock=0.
  - m1_lock is ignored while `last`==0.
  - Used for uninterrupted loader bursts.
- When undefined: no m1_lock port; pure round-robin.

Test Plan:
- Reset: hold rst=1 for 2 cycles with both req=1 -> all outputs 0; first post-reset cycle m0_gnt=1, mem_en=1.
- Single write: m1_req=1, m1_we=1, adr=0x100, wdata=0xDEADBEEF -> same cycle m1_gnt=1, mem_we=1, mem_adr=0x100, mem_wdata=0xDEADBEEF; no rvalid follows.
- Read latency: RD_LAT=3, m0 reads 0x40, memory returns 0x12345678 -> m0_gnt at cycle T; m0_rvalid=1 with m0_rdata=0x12345678 at T+3; no gnt issued at T+1 or T+2.
- Contention: both requesters read continuously, RD_LAT=1 -> grants alternate m0,m1,m0,m1; each rvalid goes to the correct requester, one cycle after its gnt.
- Reset mid-read: RD_LAT=4, issue read, assert rst at T+2 -> m0_rvalid never asserts; state is IDLE after reset.
- Lock (LOCK_EN): m1 granted with m1_lock=1 while m0_req=1 for 5 cycles -> 5 consecutive m1_gnt; drop lock -> m0_gnt on the next issue cycle.
